// File: rtl/rrarb_left_grant_ctrl.sv
// rrarb_left_grant_ctrl: registered round-robin arbiter with a leftward
// (MSB towards LSB) priority scan that starts just below the last grant.
// A grant is held while its owner keeps requesting; release re-arbitrates
// with no idle cycle in between.
// Optional feature macro: RRARB_MAX_HOLD_EN bounds how long one grant may be held.
module rrarb_left_grant_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] last_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Elaboration-time sanity check of the parameter set.
    if (WIDTH < 2 || IDX_W != $clog2(WIDTH) || MAX_HOLD < 1) begin : g_bad_param
        $error("rrarb_left_grant_ctrl: illegal WIDTH/IDX_W/MAX_HOLD combination");
    end

`ifdef RRARB_MAX_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;

    logic [WIDTH-1:0]  arb_req;
    logic [WIDTH-1:0]  masked;
    logic [IDX_W-1:0]  arb_ptr;
    logic [IDX_W-1:0]  sel;
    logic              sel_vld;
    logic              do_arb;
    logic              keep_owner;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] pick_hi(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Bits strictly below position p.
    function automatic logic [WIDTH-1:0] below_mask(input logic [IDX_W-1:0] p);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < int'(p));
        end
        return m;
    endfunction

    // Next-state decode: decide whether to arbitrate, run the scan, load grant.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        last_idx_d = last_idx_q;
        arb_req    = req;
        arb_ptr    = last_idx_q;
        do_arb     = 1'b0;
        keep_owner = 1'b0;
        masked     = '0;
        sel        = '0;
        sel_vld    = 1'b0;
`ifdef RRARB_MAX_HOLD_EN
        hold_d     = hold_q;
`endif

        case (state_q)
            IDLE: begin
                do_arb = |req;
            end
            GRANT: begin
                arb_ptr = gnt_idx_q;
                if (!req[gnt_idx_q]) begin
                    do_arb = 1'b1;
`ifdef RRARB_MAX_HOLD_EN
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    // Forced release: owner is excluded but may be re-granted if alone.
                    do_arb              = 1'b1;
                    arb_req[gnt_idx_q]  = 1'b0;
                    keep_owner          = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        masked = arb_req & below_mask(arb_ptr);
        if (|masked) begin
            sel     = pick_hi(masked);
            sel_vld = 1'b1;
        end else if (|arb_req) begin
            sel     = pick_hi(arb_req);
            sel_vld = 1'b1;
        end else if (keep_owner) begin
            sel     = gnt_idx_q;
            sel_vld = 1'b1;
        end

        if (do_arb) begin
            if (sel_vld) begin
                state_d    = GRANT;
                gnt_d      = WIDTH'(1) << sel;
                gnt_idx_d  = sel;
                gnt_vld_d  = 1'b1;
                last_idx_d = sel;
`ifdef RRARB_MAX_HOLD_EN
                hold_d     = '0;
`endif
            end else begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_idx_d  = '0;
                gnt_vld_d  = 1'b0;
`ifdef RRARB_MAX_HOLD_EN
                hold_d     = '0;
`endif
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            last_idx_q <= '0;
`ifdef RRARB_MAX_HOLD_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            last_idx_q <= last_idx_d;
`ifdef RRARB_MAX_HOLD_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign gnt_idx  = gnt_idx_q;
    assign gnt_vld  = gnt_vld_q;
    assign last_idx = last_idx_q;

endmodule
